pir_emulator: RTL and testbench
===============================

# pir_emulator

Synthesizable model of a PIR motion sensor (HC-SR501 style) that produces the `pir_in` waveform consumed by the occupancy path. A raw `motion` stimulus (push-button, test pin or bench driver) is synchronized and shaped into a realistic sensor output with warm-up, hold and lockout phases. It is the transmitting end of the PIR signal: it sits off-chip-facing, in a test build or a loopback board, and drives the same pin the occupancy detector samples.

## Interface

Parameters:
- `WARMUP_CYC`, default 1000: cycles after reset during which the sensor is inert; must be at least 1.
- `HOLD_CYC`, default 500: cycles `pir_out` stays high after the last accepted trigger; must be at least 1.
- `BLOCK_CYC`, default 200: lockout cycles after `pir_out` falls; must be at least 1.

Ports:
- `clk`, input, 1: single system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `motion`, input, 1: raw motion stimulus, asynchronous to `clk`.
- `retrig`, input, 1: mode select. 1 means retriggerable (H jumper); 0 means single-shot (L jumper). Treated as quasi-static.
- `pir_out`, output, 1: emulated sensor output, registered.
- `ready`, output, 1: high once warm-up has completed, registered.
- `trig_count`, output, 8: count of IDLE→HIGH transitions, registered.

## Operation

- `motion` passes through a 2-flop synchronizer to produce `motion_s`. All decisions use `motion_s` only.
- Counter `cnt` width is clog2 of max(`WARMUP_CYC`, `HOLD_CYC`, `BLOCK_CYC`) + 1.
- FSM states:
  - WARMUP (reset state): `cnt` increments each cycle. When `cnt == WARMUP_CYC-1`, go to IDLE and clear `cnt`. `motion_s` is ignored.
  - IDLE: if `motion_s` is 1, go to HIGH, clear `cnt`, and increment `trig_count`. Otherwise stay.
  - HIGH: `cnt` increments. If `retrig` = 1 and `motion_s` = 1, clear `cnt` instead of incrementing. If `cnt == HOLD_CYC-1` and the cycle is not a retrigger, go to BLOCK and clear `cnt`. In a simultaneous expiry and retrigger, the retrigger wins and the FSM stays in HIGH. With `retrig` = 0, `motion_s` is ignored in HIGH.
  - BLOCK: `cnt` increments. When `cnt == BLOCK_CYC-1`, go to IDLE. `motion_s` is ignored and not remembered. If `motion_s` is still 1 on arrival in IDLE, it triggers on the next IDLE cycle.
- Outputs:
  - `pir_out` = 1 exactly while the state is HIGH. It is decoded from the registered state, so it is glitch-free.
  - `ready` = 1 in IDLE, HIGH and BLOCK; 0 in WARMUP.
  - `trig_count` wraps from 255 to 0. Retriggers do not count.
- Reset values (asserted asynchronously, at any time, including mid-HIGH): state = WARMUP, `cnt` = 0, synchronizer flops = 0, `pir_out` = 0, `ready` = 0, `trig_count` = 0. Warm-up restarts in full after reset is released.

## Timing

- Reset release: `ready` rises after exactly `WARMUP_CYC` rising edges.
- Trigger latency: suppose `motion` is stable high before edge N while the FSM is in IDLE.
  - `motion_s` is valid after edge N+1.
  - The state becomes HIGH and `pir_out` = 1 after edge N+2.
  - This gives 2 cycles of latency from the sampled input to the output.
- Single trigger: `pir_out` stays high for exactly `HOLD_CYC` cycles.
- Retrigger: `pir_out` stays high until `HOLD_CYC` cycles after the last cycle in which `motion_s` = 1 was seen in HIGH.
- Lockout: `pir_out` stays low for at least `BLOCK_CYC` cycles. The earliest re-rise is `BLOCK_CYC` + 1 cycles after the fall.
- Minimum detectable pulse: `motion` must be high for ≥ 2 consecutive cycles to be guaranteed to register.
- `retrig` changes take effect on the next edge. No other handshake exists.

## Test plan

All scenarios use `WARMUP_CYC` = 8, `HOLD_CYC` = 5, `BLOCK_CYC` = 3.

1. **Reset and warm-up.** Release `rst_n`, with `motion` held at 1 throughout.
   - `ready` = 0 and `pir_out` = 0 for 8 edges.
   - `ready` = 1 after edge 8.
   - `pir_out` rises on the following edge, from pending motion in IDLE.
   - `trig_count` = 1.
2. **Single-shot.** Set `retrig` = 0. After warm-up, pulse `motion` high for 3 cycles.
   - `pir_out` rises 2 edges after the pulse is sampled.
   - `pir_out` stays high exactly 5 cycles, then is low ≥ 3 cycles.
   - `trig_count` increments by 1.
3. **Retrigger extension.** Set `retrig` = 1. Pulse `motion` at t = 0 and again at t = 4.
   - The second pulse is seen in HIGH at the final hold cycle.
   - `pir_out` stays high continuously until 5 cycles after the last `motion_s` high.
   - `trig_count` increments only once.
4. **Lockout.** A `motion` pulse arrives entirely within BLOCK.
   - No re-rise and no count change.
   - A pulse held across the BLOCK→IDLE boundary triggers on the first IDLE cycle.
5. **Wrap.** Apply 256 separated triggers.
   - `trig_count` reads 255, then 0.
6. **Mid-operation reset.** Assert `rst_n` = 0 asynchronously during HIGH.
   - `pir_out`, `ready` and `trig_count` go to 0 immediately, with no clock edge.
   - After release, the full 8-cycle warm-up repeats.

Source files
------------

// File: rtl/pir_emulator.sv
// PIR motion sensor emulator (HC-SR501 style): synchronizes a raw motion
// stimulus and shapes it into a sensor output with warm-up, hold and lockout.
module pir_emulator #(
    parameter int unsigned WARMUP_CYC = 1000,
    parameter int unsigned HOLD_CYC   = 500,
    parameter int unsigned BLOCK_CYC  = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       motion,
    input  logic       retrig,
    output logic       pir_out,
    output logic       ready,
    output logic [7:0] trig_count
);

    localparam int unsigned MAX_WH  = (WARMUP_CYC > HOLD_CYC) ? WARMUP_CYC : HOLD_CYC;
    localparam int unsigned MAX_CYC = (MAX_WH > BLOCK_CYC) ? MAX_WH : BLOCK_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned TRIG_W  = 8;

    localparam logic [CNT_W-1:0] WARMUP_LAST = CNT_W'(WARMUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] BLOCK_LAST  = CNT_W'(BLOCK_CYC - 1);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_IDLE   = 2'd1,
        ST_HIGH   = 2'd2,
        ST_BLOCK  = 2'd3
    } state_e;

    logic [1:0]        sync_q;
    logic              motion_s;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TRIG_W-1:0] trig_q, trig_d;
    logic              pir_q;
    logic              ready_q;

    // Two-flop synchronizer for the asynchronous motion stimulus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], motion};
        end
    end

    assign motion_s = sync_q[1];

    // Next-state logic; a retrigger takes priority over hold expiry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        trig_d  = trig_q;
        case (state_q)
            ST_WARMUP: begin
                if (cnt_q == WARMUP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (motion_s) begin
                    state_d = ST_HIGH;
                    trig_d  = trig_q + TRIG_W'(1);
                end
            end
            ST_HIGH: begin
                if (retrig && motion_s) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_BLOCK;
                    cnt_d   = '0;
                end
            end
            ST_BLOCK: begin
                if (cnt_q == BLOCK_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_WARMUP;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and outputs registered together so outputs track state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WARMUP;
            cnt_q   <= '0;
            trig_q  <= '0;
            pir_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            pir_q   <= (state_d == ST_HIGH);
            ready_q <= (state_d != ST_WARMUP);
        end
    end

    assign pir_out    = pir_q;
    assign ready      = ready_q;
    assign trig_count = trig_q;

endmodule

// File: tb/tb_pir_emulator.sv
// Directed self-checking bench for pir_emulator with WARMUP=8, HOLD=5, BLOCK=3.
module tb_pir_emulator;

    logic       clk;
    logic       rst_n;
    logic       motion;
    logic       retrig;
    logic       pir_out;
    logic       ready;
    logic [7:0] trig_count;

    int n_checks = 0;
    int n_pass   = 0;

    pir_emulator #(
        .WARMUP_CYC(8),
        .HOLD_CYC  (5),
        .BLOCK_CYC (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .motion    (motion),
        .retrig    (retrig),
        .pir_out   (pir_out),
        .ready     (ready),
        .trig_count(trig_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic warmup_seq(input string tag);
        for (int i = 1; i <= 8; i++) begin
            step();
            check({tag, "_ready"}, ready, (i == 8) ? 1 : 0);
            check({tag, "_pir"}, pir_out, 0);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        motion = 1'b1;
        retrig = 1'b0;
        #23;
        check("rst_pir", pir_out, 0);
        check("rst_ready", ready, 0);
        check("rst_count", trig_count, 0);

        // 1: warm-up with motion held high, then pending trigger
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        warmup_seq("warm");
        step();
        check("t1_rise", pir_out, 1);
        check("t1_count", trig_count, 1);
        motion = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1_hold", pir_out, 1);
        end
        step();
        check("t1_fall", pir_out, 0);
        for (int i = 0; i < 5; i++) step();

        // 2: single-shot, 3-cycle pulse
        retrig = 1'b0;
        motion = 1'b1;
        step();
        check("t2_lat0", pir_out, 0);
        step();
        check("t2_lat1", pir_out, 0);
        step();
        check("t2_rise", pir_out, 1);
        motion = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_hold", pir_out, 1);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_low", pir_out, 0);
        end
        check("t2_count", trig_count, 2);

        // 3: retrigger seen at the final hold cycle extends the pulse
        retrig = 1'b1;
        motion = 1'b1;
        step();
        motion = 1'b0;
        step();
        check("t3_lat", pir_out, 0);
        step();
        check("t3_rise", pir_out, 1);
        step();
        step();
        motion = 1'b1;
        step();
        check("t3_hold3", pir_out, 1);
        motion = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t3_ext", pir_out, 1);
        end
        // 4a: pulse that lives entirely inside BLOCK
        motion = 1'b1;
        step();
        check("t3_fall", pir_out, 0);
        check("t3_count", trig_count, 3);
        step();
        check("t4_block", pir_out, 0);
        motion = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_norise", pir_out, 0);
        end
        check("t4_count", trig_count, 3);

        // 4b: pulse held across BLOCK->IDLE fires on the first IDLE cycle
        retrig = 1'b0;
        motion = 1'b1;
        step();
        motion = 1'b0;
        step();
        step();
        check("t4b_rise", pir_out, 1);
        for (int i = 0; i < 4; i++) step();
        check("t4b_hold", pir_out, 1);
        step();
        check("t4b_fall", pir_out, 0);
        motion = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4b_lock", pir_out, 0);
        end
        motion = 1'b0;
        step();
        check("t4b_rerise", pir_out, 1);
        check("t4b_count", trig_count, 5);
        for (int i = 0; i < 12; i++) step();

        // 5: wrap of trig_count
        for (int n = 0; n < 250; n++) begin
            motion = 1'b1;
            step();
            motion = 1'b0;
            for (int i = 0; i < 12; i++) step();
        end
        check("t5_255", trig_count, 255);
        motion = 1'b1;
        step();
        motion = 1'b0;
        step();
        step();
        check("t5_wrap", trig_count, 0);
        check("t5_pir", pir_out, 1);
        for (int i = 0; i < 10; i++) step();

        // 6: asynchronous reset in the middle of HIGH
        motion = 1'b1;
        step();
        motion = 1'b0;
        step();
        step();
        check("t6_rise", pir_out, 1);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_pir", pir_out, 0);
        check("t6_rst_ready", ready, 0);
        check("t6_rst_count", trig_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        warmup_seq("rewarm");
        step();
        check("t6_idle_pir", pir_out, 0);
        check("t6_idle_count", trig_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
